// File: rtl/fetch_unpacker.sv
// Instruction fetch stage that feeds the decoder.
// It requests one 64-byte line at a time on the Sysbus and splits each
// 64-bit response beat into two 32-bit instruction words. Each word is
// buffered with its PC in a FIFO. Fetching stops at the first all-zero word.
//
// Handshakes:
//   bus_reqcyc/bus_reqack : the request is valid while reqcyc=1. bus_req and
//                           bus_reqtag are held until the cycle in which
//                           reqack=1 is sampled.
//   bus_respcyc/bus_respack : respack mirrors respcyc during a line transfer.
//                           There is no backpressure: FIFO room for a full line
//                           is reserved before the request is issued.
//   inst_valid/inst_ready : a word transfers on the clock edge where both are 1.
//                           inst/inst_pc are held while valid=1 and ready=0.
module fetch_unpacker #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int LINE_BEATS     = 8,
  parameter int FIFO_DEPTH     = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [BUS_DATA_WIDTH-1:0] entry,
  input  logic                      start,
  output logic                      bus_reqcyc,
  input  logic                      bus_reqack,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack,
  output logic                      inst_valid,
  input  logic                      inst_ready,
  output logic [31:0]               inst,
  output logic [BUS_DATA_WIDTH-1:0] inst_pc,
  output logic                      done,
  output logic [2:0]                dbg_state
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int BEAT_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  // Sysbus tag: bit[12]=READ, bits[11:8]=MEMORY (4'b0001), low bits zero.
  localparam logic [BUS_TAG_WIDTH-1:0] TAG_READ_MEM =
    {1'b1, 4'b0001, {(BUS_TAG_WIDTH-5){1'b0}}};
  // A new line is requested only when at least a full line of entries is free.
  localparam logic [PTR_W:0] WAIT_LIMIT = (PTR_W+1)'(FIFO_DEPTH - 2*LINE_BEATS);
  localparam logic [BUS_DATA_WIDTH-1:0] LINE_BYTES = BUS_DATA_WIDTH'(LINE_BEATS*8);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS-1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REQ_WAIT = 3'd1,
    S_REQ      = 3'd2,
    S_RESP     = 3'd3,
    S_DRAIN    = 3'd4,
    S_DONE     = 3'd5
  } state_e;

  state_e                    state_q, state_d;
  logic [BUS_DATA_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
  logic [BEAT_W-1:0]         beat_cnt_q, beat_cnt_d;
  logic                      stop_q, stop_d;
  logic [PTR_W:0]            wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]            rd_ptr_q, rd_ptr_d;

  logic [31:0]               mem_inst [FIFO_DEPTH];
  logic [BUS_DATA_WIDTH-1:0] mem_pc   [FIFO_DEPTH];

  logic                      push_lo, push_hi, pop;
  logic [PTR_W:0]            count;
  logic                      fifo_empty;
  logic [PTR_W-1:0]          wr_idx0, wr_idx1, rd_idx;
  logic [31:0]               word_lo, word_hi;
  logic [BUS_DATA_WIDTH-1:0] beat_pc;

  // The low entry bits are forced to zero and the response tag is not checked.
  logic unused_ok;
  assign unused_ok = ^{entry[5:0], bus_resptag};

  assign word_lo    = bus_resp[31:0];
  assign word_hi    = bus_resp[63:32];
  assign beat_pc    = fetch_addr_q + (BUS_DATA_WIDTH'(beat_cnt_q) << 3);
  assign count      = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (count == '0);
  assign wr_idx0    = wr_ptr_q[PTR_W-1:0];
  assign wr_idx1    = wr_ptr_q[PTR_W-1:0] + PTR_W'(1);
  assign rd_idx     = rd_ptr_q[PTR_W-1:0];
  assign inst_valid = !fifo_empty;
  assign pop        = inst_valid & inst_ready;
  assign inst       = fifo_empty ? '0 : mem_inst[rd_idx];
  assign inst_pc    = fifo_empty ? '0 : mem_pc[rd_idx];
  assign dbg_state  = state_q;

  // Next-state logic, bus outputs and the zero-word stop decision.
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    beat_cnt_d   = beat_cnt_q;
    stop_d       = stop_q;
    push_lo      = 1'b0;
    push_hi      = 1'b0;
    bus_reqcyc   = 1'b0;
    bus_req      = '0;
    bus_reqtag   = '0;
    bus_respack  = 1'b0;
    done         = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        done = (state_q == S_DONE);
        if (start) begin
          fetch_addr_d = {entry[BUS_DATA_WIDTH-1:6], 6'b0};
          stop_d       = 1'b0;
          state_d      = S_REQ_WAIT;
        end
      end
      S_REQ_WAIT: begin
        if (count <= WAIT_LIMIT) state_d = S_REQ;
      end
      S_REQ: begin
        bus_reqcyc = 1'b1;
        bus_req    = fetch_addr_q;
        bus_reqtag = TAG_READ_MEM;
        if (bus_reqack) begin
          beat_cnt_d = '0;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        bus_respack = bus_respcyc;
        if (bus_respcyc) begin
          // Once stopped, remaining beats are acknowledged but discarded.
          if (!stop_q) begin
            if (word_lo == 32'h0) begin
              stop_d = 1'b1;
            end else begin
              push_lo = 1'b1;
              if (word_hi == 32'h0) stop_d = 1'b1;
              else                  push_hi = 1'b1;
            end
          end
          beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          if (beat_cnt_q == LAST_BEAT) begin
            if (stop_d) begin
              state_d = S_DRAIN;
            end else begin
              fetch_addr_d = fetch_addr_q + LINE_BYTES;
              state_d      = S_REQ_WAIT;
            end
          end
        end
      end
      S_DRAIN: begin
        if (fifo_empty) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO pointers advance by the number of words pushed and popped this cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q + (PTR_W+1)'(push_lo) + (PTR_W+1)'(push_hi);
    rd_ptr_d = rd_ptr_q + (PTR_W+1)'(pop);
  end

  // Control state and FIFO pointers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      fetch_addr_q <= '0;
      beat_cnt_q   <= '0;
      stop_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      beat_cnt_q   <= beat_cnt_d;
      stop_q       <= stop_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // FIFO storage: two-word write port with no reset (outputs are gated by empty).
  always_ff @(posedge clk) begin
    if (push_lo) begin
      mem_inst[wr_idx0] <= word_lo;
      mem_pc[wr_idx0]   <= beat_pc;
    end
    if (push_hi) begin
      mem_inst[wr_idx1] <= word_hi;
      mem_pc[wr_idx1]   <= beat_pc + BUS_DATA_WIDTH'(4);
    end
  end

endmodule

// File: tb/tb_fetch_unpacker.sv
// Bench for fetch_unpacker. A line responder serves reads from a sparse
// program image, in which unmapped words read as nop. While it drives each
// beat it pushes the instructions that should come out. A monitor pops
// them and compares them against the decoder-side output.
module tb_fetch_unpacker;
  localparam int LB = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] entry = '0;
  logic        start = 1'b0;
  logic        bus_reqcyc;
  logic        bus_reqack = 1'b0;
  logic [63:0] bus_req;
  logic [12:0] bus_reqtag;
  logic        bus_respcyc = 1'b0;
  logic [63:0] bus_resp = '0;
  logic [12:0] bus_resptag = '0;
  logic        bus_respack;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        done;
  logic [2:0]  dbg_state;

  fetch_unpacker dut (
    .clk(clk), .reset(reset), .entry(entry), .start(start),
    .bus_reqcyc(bus_reqcyc), .bus_reqack(bus_reqack), .bus_req(bus_req),
    .bus_reqtag(bus_reqtag), .bus_respcyc(bus_respcyc), .bus_resp(bus_resp),
    .bus_resptag(bus_resptag), .bus_respack(bus_respack),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .done(done), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  int          n_req = 0;
  int          n_out = 0;
  int          n_beats = 0;
  int          ack_delay = 0;
  logic        rsp_kill = 1'b0;
  logic [63:0] last_pc = '0;
  logic [95:0] exp_q[$];
  logic [63:0] req_log[$];
  int          out_at_req[$];
  logic [31:0] prog[bit [63:0]];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] prog_word(input logic [63:0] a);
    if (prog.exists(a)) return prog[a];
    return 32'h00000013;
  endfunction

  // Line responder: it acks requests after ack_delay cycles, checks that the
  // request is held stable, then drives 8 beats and queues the expected words.
  initial begin : responder
    logic [63:0] ra;
    logic [12:0] rt;
    logic        stop;
    logic [31:0] lo, hi;
    logic [63:0] pc;
    forever begin
      @(negedge clk);
      if (reset && bus_reqcyc) begin
        ra = bus_req;
        rt = bus_reqtag;
        n_req++;
        req_log.push_back(ra);
        out_at_req.push_back(n_out);
        check("req_tag_read_mem", 64'(rt), 64'h1100);
        for (int d = 0; d < ack_delay; d++) begin
          check("no_respack_before_ack", 64'(bus_respack), 64'd0);
          @(negedge clk);
          check("req_addr_held", bus_req, ra);
          check("req_tag_held", 64'(bus_reqtag), 64'(rt));
          check("reqcyc_held", 64'(bus_reqcyc), 64'd1);
        end
        bus_reqack = 1'b1;
        @(negedge clk);
        bus_reqack = 1'b0;
        stop = 1'b0;
        for (int b = 0; b < LB && !rsp_kill; b++) begin
          pc = ra + 64'(8 * b);
          lo = prog_word(pc);
          hi = prog_word(pc + 64'd4);
          if (!stop) begin
            if (lo == 32'h0) stop = 1'b1;
            else begin
              exp_q.push_back({pc, lo});
              if (hi == 32'h0) stop = 1'b1;
              else exp_q.push_back({pc + 64'd4, hi});
            end
          end
          bus_respcyc = 1'b1;
          bus_resp = {hi, lo};
          #1;
          check("respack_beat", 64'(bus_respack), 64'd1);
          n_beats++;
          @(negedge clk);
        end
        bus_respcyc = 1'b0;
        bus_resp = '0;
      end
    end
  end

  // Decoder-side monitor: it pops the scoreboard on each accepted instruction
  // and checks that the head is held while the decoder stalls.
  initial begin : monitor
    logic [95:0] e;
    logic        held;
    logic [31:0] h_inst;
    logic [63:0] h_pc;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (reset && inst_valid) begin
        if (held) begin
          check("hold_inst", 64'(inst), 64'(h_inst));
          check("hold_pc", inst_pc, h_pc);
        end
        if (inst_ready) begin
          held = 1'b0;
          n_out++;
          last_pc = inst_pc;
          if (exp_q.size() == 0) begin
            check("unexpected_inst_valid", 64'(inst_valid), 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("inst_word", 64'(inst), 64'(e[31:0]));
            check("inst_pc", inst_pc, e[95:32]);
          end
        end else begin
          held = 1'b1;
          h_inst = inst;
          h_pc = inst_pc;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  task automatic set_ready(input logic v);
    @(posedge clk); #1;
    inst_ready = v;
  endtask

  task automatic pulse_start(input logic [63:0] e);
    @(posedge clk); #1;
    entry = e;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    entry = '0;
    check("done_low_after_start", 64'(done), 64'd0);
  endtask

  task automatic wait_done(input string tag, input int max);
    int c;
    c = 0;
    while (!done && c < max) begin
      @(negedge clk);
      c++;
    end
    check(tag, 64'(done), 64'd1);
  endtask

  task automatic finish_test(input string tag, input int o0, input int r0,
                             input int exp_out, input int exp_req, input logic [63:0] addr0);
    repeat (5) @(negedge clk);
    check({tag, "_scoreboard_empty"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_inst_count"}, 64'(n_out - o0), 64'(exp_out));
    check({tag, "_req_count"}, 64'(n_req - r0), 64'(exp_req));
    if (req_log.size() > r0) check({tag, "_first_req_addr"}, req_log[r0], addr0);
    else check({tag, "_first_req_seen"}, 64'(req_log.size()), 64'(r0 + 1));
    check({tag, "_done_held"}, 64'(done), 64'd1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_reqcyc"}, 64'(bus_reqcyc), 64'd0);
    check({tag, "_req"}, bus_req, 64'd0);
    check({tag, "_reqtag"}, 64'(bus_reqtag), 64'd0);
    check({tag, "_respack"}, 64'(bus_respack), 64'd0);
    check({tag, "_inst_valid"}, 64'(inst_valid), 64'd0);
    check({tag, "_inst"}, 64'(inst), 64'd0);
    check({tag, "_inst_pc"}, inst_pc, 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
  endtask

  initial begin : watchdog
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int o0, r0, b0, c;
    // reset
    repeat (3) @(negedge clk);
    check_outputs_zero("in_reset");
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_outputs_zero("idle_after_reset");
    check("idle_state", 64'(dbg_state), 64'd0);
    set_ready(1'b1);

    // single line, stop on high word of last beat
    prog.delete();
    prog[64'h103C] = 32'h0;
    o0 = n_out; r0 = n_req;
    pulse_start(64'h1000);
    wait_done("t1_done", 300);
    finish_test("t1", o0, r0, 15, 1, 64'h1000);
    check("t1_last_pc", last_pc, 64'h1038);

    // misaligned entry rounds down to the line
    prog.delete();
    prog[64'h1008] = 32'h0;
    o0 = n_out; r0 = n_req;
    pulse_start(64'h1024);
    wait_done("t2_done", 300);
    finish_test("t2", o0, r0, 2, 1, 64'h1000);

    // zero in low half of beat 2: high half dropped, rest acked
    prog.delete();
    prog[64'h3010] = 32'h0;
    prog[64'h3014] = 32'h00100093;
    o0 = n_out; r0 = n_req; b0 = n_beats;
    pulse_start(64'h3000);
    wait_done("t3_done", 300);
    finish_test("t3", o0, r0, 4, 1, 64'h3000);
    check("t3_all_beats_acked", 64'(n_beats - b0), 64'd8);

    // backpressure across a 3-line program
    set_ready(1'b0);
    prog.delete();
    prog[64'h20BC] = 32'h0;
    o0 = n_out; r0 = n_req;
    pulse_start(64'h2000);
    repeat (40) @(negedge clk);
    check("bp_two_reqs", 64'(n_req - r0), 64'd2);
    check("bp_reqcyc_low", 64'(bus_reqcyc), 64'd0);
    check("bp_state_req_wait", 64'(dbg_state), 64'd1);
    check("bp_valid", 64'(inst_valid), 64'd1);
    check("bp_head_pc", inst_pc, 64'h2000);
    check("bp_no_pops", 64'(n_out - o0), 64'd0);
    set_ready(1'b1);
    wait_done("bp_done", 500);
    finish_test("bp", o0, r0, 47, 3, 64'h2000);
    if (out_at_req.size() > r0 + 2)
      check("bp_third_req_after_16_pops", 64'((out_at_req[r0 + 2] - o0) >= 16), 64'd1);
    else
      check("bp_third_req_seen", 64'(out_at_req.size()), 64'(r0 + 3));
    if (req_log.size() > r0 + 2)
      check("bp_third_req_addr", req_log[r0 + 2], 64'h2080);

    // request stall: ack held off 5 cycles
    ack_delay = 5;
    prog.delete();
    prog[64'h5008] = 32'h0;
    o0 = n_out; r0 = n_req;
    pulse_start(64'h5000);
    wait_done("stall_done", 300);
    finish_test("stall", o0, r0, 2, 1, 64'h5000);
    ack_delay = 0;

    // reset in the middle of a response, then a clean restart
    prog.delete();
    prog[64'h603C] = 32'h0;
    b0 = n_beats;
    pulse_start(64'h6000);
    c = 0;
    while ((n_beats - b0) < 4 && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("rst_reached_beat3", 64'((n_beats - b0) >= 4), 64'd1);
    #2;
    rsp_kill = 1'b1;
    reset = 1'b0;
    #1;
    check_outputs_zero("mid_resp_reset");
    check("mid_resp_reset_state", 64'(dbg_state), 64'd0);
    repeat (2) @(negedge clk);
    exp_q.delete();
    rsp_kill = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_outputs_zero("after_reset_release");
    prog.delete();
    prog[64'h4010] = 32'h0;
    o0 = n_out; r0 = n_req;
    pulse_start(64'h4000);
    wait_done("restart_done", 300);
    finish_test("restart", o0, r0, 4, 1, 64'h4000);
    check("restart_last_pc", last_pc, 64'h400C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
